// File: rtl/decode_sequencer.sv
// decode_sequencer
//   Multi-cycle decode/writeback sequencer sitting in front of the 16x18-bit
//   register file. One instruction in flight at a time: accept, read operands,
//   run the external ALU (bounded wait), write back, retire.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   instr_valid_i/instr_i        upstream instruction handshake (with instr_ready_o)
//   read_enable*/read_register*  register-file read request, issued in DECODE
//   read_data*_i                 register-file read data, valid in READ
//   write_register/data, reg_write  one-cycle register-file write
//   alu_op/operand_a/operand_b/alu_start  ALU request, alu_result_i/alu_done_i reply
//   illegal_instr_o, alu_error_o  one-cycle event pulses
//   halted_o, retired_count_o     status
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for an instruction; read request registered on accept
// S_DECODE | register file is performing the read
// S_READ   | read data valid; dispatch to ALU, writeback, retire or halt
// S_EXEC   | waiting for alu_done_i, down-counter bounds the wait
// S_WB     | result final; write strobe and retire registered on exit
// S_HALTED | HALT executed, only reset leaves
module decode_sequencer #(
   parameter int DATA_WIDTH  = 18,
   parameter int ADDR_WIDTH  = 4,
   parameter int ALU_TIMEOUT = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  instr_valid_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   output logic                  instr_ready_o,
   output logic                  read_enable1_o,
   output logic                  read_enable2_o,
   output logic [ADDR_WIDTH-1:0] read_register1_o,
   output logic [ADDR_WIDTH-1:0] read_register2_o,
   input  logic [DATA_WIDTH-1:0] read_data1_i,
   input  logic [DATA_WIDTH-1:0] read_data2_i,
   output logic [ADDR_WIDTH-1:0] write_register_o,
   output logic [DATA_WIDTH-1:0] write_data_o,
   output logic                  reg_write_o,
   output logic [2:0]            alu_op_o,
   output logic [DATA_WIDTH-1:0] operand_a_o,
   output logic [DATA_WIDTH-1:0] operand_b_o,
   output logic                  alu_start_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  alu_done_i,
   output logic                  illegal_instr_o,
   output logic                  alu_error_o,
   output logic                  halted_o,
   output logic [15:0]           retired_count_o
);

   localparam int TMR_W = $clog2(ALU_TIMEOUT + 1);

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_ADDI = 4'b0110;
   localparam logic [3:0] OP_LDI  = 4'b0111;
   localparam logic [3:0] OP_MOV  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB, S_HALTED
   } state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   instr_q;
   logic [DATA_WIDTH-1:0]   result_q;
   logic [TMR_W-1:0]        tmr_q;
   logic                    rd_en1_q, rd_en2_q, reg_write_q, alu_start_q;
   logic                    illegal_q, alu_error_q, halted_q;
   logic [ADDR_WIDTH-1:0]   rd_reg1_q, rd_reg2_q, wr_reg_q;
   logic [DATA_WIDTH-1:0]   wr_data_q, opa_q, opb_q;
   logic [2:0]              alu_op_q;
   logic [15:0]             retired_q;

   logic                    use_rd1_d, use_rd2_d;
   logic [15:0]             retired_d;
   logic [3:0]              opc;

   // Port usage is decoded from the incoming word so the read request is
   // already on the bus during the DECODE cycle.
   always_comb begin
      use_rd1_d = 1'b0;
      use_rd2_d = 1'b0;
      case (instr_i[17:14])
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            use_rd1_d = 1'b1;
            use_rd2_d = 1'b1;
         end
         OP_ADDI, OP_MOV: use_rd1_d = 1'b1;
         default: ;
      endcase
   end

   assign opc       = instr_q[17:14];
   assign retired_d = retired_q + 16'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         result_q    <= '0;
         tmr_q       <= '0;
         rd_en1_q    <= 1'b0;
         rd_en2_q    <= 1'b0;
         rd_reg1_q   <= '0;
         rd_reg2_q   <= '0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
         reg_write_q <= 1'b0;
         alu_op_q    <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         alu_start_q <= 1'b0;
         illegal_q   <= 1'b0;
         alu_error_q <= 1'b0;
         halted_q    <= 1'b0;
         retired_q   <= '0;
      end else begin
         rd_en1_q    <= 1'b0;
         rd_en2_q    <= 1'b0;
         reg_write_q <= 1'b0;
         alu_start_q <= 1'b0;
         illegal_q   <= 1'b0;
         alu_error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (instr_valid_i) begin
                  instr_q   <= instr_i;
                  rd_en1_q  <= use_rd1_d;
                  rd_en2_q  <= use_rd2_d;
                  rd_reg1_q <= instr_i[9:6];
                  rd_reg2_q <= instr_i[5:2];
                  state_q   <= S_DECODE;
               end
            end
            S_DECODE: state_q <= S_READ;
            S_READ: begin
               case (opc)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                     opa_q       <= read_data1_i;
                     opb_q       <= (opc == OP_ADDI) ?
                                    {{(DATA_WIDTH-6){instr_q[5]}}, instr_q[5:0]} :
                                    read_data2_i;
                     alu_op_q    <= instr_q[16:14];
                     alu_start_q <= 1'b1;
                     tmr_q       <= TMR_W'(ALU_TIMEOUT - 1);
                     state_q     <= S_EXEC;
                  end
                  OP_LDI: begin
                     result_q <= {{(DATA_WIDTH-10){1'b0}}, instr_q[9:0]};
                     state_q  <= S_WB;
                  end
                  OP_MOV: begin
                     result_q <= read_data1_i;
                     state_q  <= S_WB;
                  end
                  OP_HALT: begin
                     halted_q  <= 1'b1;
                     retired_q <= retired_d;
                     state_q   <= S_HALTED;
                  end
                  default: begin
                     illegal_q <= (opc != OP_NOP);
                     retired_q <= retired_d;
                     state_q   <= S_IDLE;
                  end
               endcase
            end
            S_EXEC: begin
               // A done on the last allowed cycle still wins over the timeout.
               if (alu_done_i) begin
                  result_q <= alu_result_i;
                  state_q  <= S_WB;
               end else if (tmr_q == '0) begin
                  alu_error_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            S_WB: begin
               reg_write_q <= 1'b1;
               wr_reg_q    <= instr_q[13:10];
               wr_data_q   <= result_q;
               retired_q   <= retired_d;
               state_q     <= S_IDLE;
            end
            S_HALTED: state_q <= S_HALTED;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign instr_ready_o    = (state_q == S_IDLE);
   assign read_enable1_o   = rd_en1_q;
   assign read_enable2_o   = rd_en2_q;
   assign read_register1_o = rd_reg1_q;
   assign read_register2_o = rd_reg2_q;
   assign write_register_o = wr_reg_q;
   assign write_data_o     = wr_data_q;
   assign reg_write_o      = reg_write_q;
   assign alu_op_o         = alu_op_q;
   assign operand_a_o      = opa_q;
   assign operand_b_o      = opb_q;
   assign alu_start_o      = alu_start_q;
   assign illegal_instr_o  = illegal_q;
   assign alu_error_o      = alu_error_q;
   assign halted_o         = halted_q;
   assign retired_count_o  = retired_q;

endmodule
